// File: rtl/sfp_acc_act.sv
// Per-column post-processor: accumulates acc_len partial-sum vectors with signed
// saturation, then applies bypass / ReLU / leaky ReLU and pulses out_valid.
module sfp_acc_act #(
    parameter int bw     = 16,
    parameter int psum_bw = 20,
    parameter int col    = 8,
    parameter int cnt_bw = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [bw*col-1:0]        in,
    input  logic [cnt_bw-1:0]        acc_len,
    input  logic [1:0]               mode,
    input  logic [3:0]               leak_shift,
    output logic                     out_valid,
    output logic [psum_bw*col-1:0]   out,
    output logic [col-1:0]           out_sat,
    output logic                     busy
);

    typedef enum logic {IDLE, ACC} state_t;

    localparam logic [cnt_bw-1:0]        one     = 1;
    localparam logic signed [psum_bw:0]  sat_max = {2'b00, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw:0]  sat_min = {2'b11, {(psum_bw-1){1'b0}}};

    state_t state, state_next;

    logic [cnt_bw-1:0]          count;
    logic [cnt_bw-1:0]          len_q;
    logic [1:0]                 mode_q;
    logic [3:0]                 shift_q;
    logic [col-1:0]             sat_q;
    logic signed [psum_bw-1:0]  acc [col];

    logic [cnt_bw-1:0]          eff_len;
    logic [1:0]                 eff_mode;
    logic [3:0]                 eff_shift;
    logic [cnt_bw-1:0]          count_inc;
    logic                       done;

    logic signed [bw-1:0]       lane_in  [col];
    logic signed [psum_bw:0]    lane_sum [col];
    logic signed [psum_bw-1:0]  lane_clamped [col];
    logic signed [psum_bw-1:0]  lane_act [col];
    logic [col-1:0]             lane_sat;
    logic [psum_bw*col-1:0]     act_packed;

    // A group's parameters come straight from the ports on its first sample,
    // and from the latched copies for every later sample.
    always_comb begin
        eff_len   = len_q;
        eff_mode  = mode_q;
        eff_shift = shift_q;
        if (state == IDLE) begin
            eff_len   = (acc_len == '0) ? one : acc_len;
            eff_mode  = mode;
            eff_shift = leak_shift;
        end
        count_inc = count + one;
        done      = in_valid && (count_inc == eff_len);
    end

    always_comb begin
        lane_sat   = '0;
        act_packed = '0;
        for (int i = 0; i < col; i++) begin
            lane_in[i]  = in[bw*i +: bw];
            lane_sum[i] = {acc[i][psum_bw-1], acc[i]}
                        + {{(psum_bw+1-bw){lane_in[i][bw-1]}}, lane_in[i]};
            if (lane_sum[i] > sat_max) begin
                lane_clamped[i] = sat_max[psum_bw-1:0];
                lane_sat[i]     = 1'b1;
            end else if (lane_sum[i] < sat_min) begin
                lane_clamped[i] = sat_min[psum_bw-1:0];
                lane_sat[i]     = 1'b1;
            end else begin
                lane_clamped[i] = lane_sum[i][psum_bw-1:0];
            end
            case (eff_mode)
                2'd1:    lane_act[i] = lane_clamped[i][psum_bw-1] ? '0 : lane_clamped[i];
                2'd2:    lane_act[i] = lane_clamped[i][psum_bw-1]
                                     ? (lane_clamped[i] >>> eff_shift) : lane_clamped[i];
                default: lane_act[i] = lane_clamped[i];
            endcase
            act_packed[psum_bw*i +: psum_bw] = lane_act[i];
        end
    end

    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else if (in_valid) begin
            state_next = done ? IDLE : ACC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // clr outranks both accumulation and completion, so an aborted group never pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            len_q     <= '0;
            mode_q    <= '0;
            shift_q   <= '0;
            sat_q     <= '0;
            out       <= '0;
            out_sat   <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < col; i++) acc[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                count <= '0;
                sat_q <= '0;
                for (int i = 0; i < col; i++) acc[i] <= '0;
            end else if (in_valid) begin
                if (state == IDLE) begin
                    len_q   <= eff_len;
                    mode_q  <= eff_mode;
                    shift_q <= eff_shift;
                end
                if (done) begin
                    out       <= act_packed;
                    out_sat   <= sat_q | lane_sat;
                    out_valid <= 1'b1;
                    count     <= '0;
                    sat_q     <= '0;
                    for (int i = 0; i < col; i++) acc[i] <= '0;
                end else begin
                    count <= count_inc;
                    sat_q <= sat_q | lane_sat;
                    for (int i = 0; i < col; i++) acc[i] <= lane_clamped[i];
                end
            end
        end
    end

    assign busy = (count != '0);

endmodule

// File: tb/tb_sfp_acc_act.sv
// Bench for sfp_acc_act: an integer group-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sfp_acc_act;

    localparam int bw      = 16;
    localparam int psum_bw = 20;
    localparam int col     = 8;
    localparam int cnt_bw  = 8;
    localparam int max_val = 524287;
    localparam int min_val = -524288;

    logic                    clk;
    logic                    reset;
    logic                    clr;
    logic                    in_valid;
    logic [bw*col-1:0]       in;
    logic [cnt_bw-1:0]       acc_len;
    logic [1:0]              mode;
    logic [3:0]              leak_shift;
    logic                    out_valid;
    logic [psum_bw*col-1:0]  out;
    logic [col-1:0]          out_sat;
    logic                    busy;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    int             m_acc [col];
    logic [col-1:0] m_sat   = '0;
    int             m_count = 0;
    int             m_len   = 0;
    int             m_mode  = 0;
    int             m_shift = 0;
    int             e_out [col];
    logic [col-1:0] e_sat   = '0;
    logic           e_valid = 1'b0;

    sfp_acc_act #(.bw(bw), .psum_bw(psum_bw), .col(col), .cnt_bw(cnt_bw)) dut (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in(in),
        .acc_len(acc_len), .mode(mode), .leak_shift(leak_shift),
        .out_valid(out_valid), .out(out), .out_sat(out_sat), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic int dut_lane(input int i);
        logic signed [psum_bw-1:0] v;
        v = out[i*psum_bw +: psum_bw];
        return int'(v);
    endfunction

    function automatic int in_lane(input int i);
        logic signed [bw-1:0] v;
        v = in[i*bw +: bw];
        return int'(v);
    endfunction

    // Leaky mode divides by 2^shift with floor rounding.
    function automatic int activate(input int x, input int md, input int sh);
        int d;
        if (md == 1) return (x < 0) ? 0 : x;
        if (md == 2 && x < 0) begin
            d = 1 << sh;
            return (x - (d - 1)) / d;
        end
        return x;
    endfunction

    task automatic clear_group();
        m_count = 0;
        m_sat   = '0;
        for (int i = 0; i < col; i++) m_acc[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < col; i++) begin
            m_acc[i] = 0;
            e_out[i] = 0;
        end
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                clear_group();
                m_len = 0; m_mode = 0; m_shift = 0;
                e_valid = 1'b0;
                e_sat   = '0;
                for (int i = 0; i < col; i++) e_out[i] = 0;
            end else begin
                e_valid = 1'b0;
                if (clr) begin
                    clear_group();
                end else if (in_valid) begin
                    if (m_count == 0) begin
                        m_len   = (acc_len == 0) ? 1 : int'(acc_len);
                        m_mode  = int'(mode);
                        m_shift = int'(leak_shift);
                    end
                    for (int i = 0; i < col; i++) begin
                        m_acc[i] = m_acc[i] + in_lane(i);
                        if (m_acc[i] > max_val) begin m_acc[i] = max_val; m_sat[i] = 1'b1; end
                        if (m_acc[i] < min_val) begin m_acc[i] = min_val; m_sat[i] = 1'b1; end
                    end
                    m_count++;
                    if (m_count == m_len) begin
                        for (int i = 0; i < col; i++) e_out[i] = activate(m_acc[i], m_mode, m_shift);
                        e_sat   = m_sat;
                        e_valid = 1'b1;
                        clear_group();
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
            check_output("out_valid", longint'(out_valid), longint'(e_valid));
            check_output("busy", longint'(busy), longint'(m_count != 0));
            check_output("out_sat", longint'(out_sat), longint'(e_sat));
            for (int i = 0; i < col; i++)
                check_output($sformatf("out[%0d]", i), longint'(dut_lane(i)), longint'(e_out[i]));
        end
    end

    task automatic apply_stimulus(input logic v, input int l0, input int l1);
        in_valid = v;
        in       = '0;
        in[0 +: bw]  = l0[bw-1:0];
        in[bw +: bw] = l1[bw-1:0];
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in       = '0;
        repeat (n) @(negedge clk);
    endtask

    int p0;

    initial begin
        reset = 1'b1; clr = 1'b0; in_valid = 1'b0; in = '0;
        acc_len = 8'd1; mode = 2'd0; leak_shift = 4'd0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_out_valid", longint'(out_valid), 0);
        check_output("reset_busy", longint'(busy), 0);
        check_output("reset_out", longint'(out != '0), 0);
        reset = 1'b1;
        @(negedge clk);

        // ReLU group
        acc_len = 8'd3; mode = 2'd1;
        apply_stimulus(1'b1, 5, -5);
        apply_stimulus(1'b1, -2, 1);
        apply_stimulus(1'b1, 4, 1);
        check_output("relu_valid", longint'(out_valid), 1);
        check_output("relu_lane0", longint'(dut_lane(0)), 7);
        check_output("relu_lane1", longint'(dut_lane(1)), 0);
        check_output("relu_sat", longint'(out_sat), 0);
        idle(1);
        check_output("relu_pulse_end", longint'(out_valid), 0);

        // Leaky ReLU, single-sample group
        acc_len = 8'd1; mode = 2'd2; leak_shift = 4'd2;
        apply_stimulus(1'b1, -9, 12);
        check_output("leaky_lane0", longint'(dut_lane(0)), -3);
        check_output("leaky_lane1", longint'(dut_lane(1)), 12);
        idle(1);

        // Saturation in both directions
        acc_len = 8'd20; mode = 2'd0; leak_shift = 4'd0;
        repeat (20) apply_stimulus(1'b1, 32767, -32768);
        check_output("sat_lane0", longint'(dut_lane(0)), 524287);
        check_output("sat_lane1", longint'(dut_lane(1)), -524288);
        check_output("sat_flags", longint'(out_sat), 3);
        idle(1);

        // Back-to-back groups with gaps
        acc_len = 8'd2;
        p0 = pulses;
        apply_stimulus(1'b1, 1, 0);
        apply_stimulus(1'b1, 2, 0);
        check_output("b2b_first_valid", longint'(out_valid), 1);
        check_output("b2b_first_lane0", longint'(dut_lane(0)), 3);
        apply_stimulus(1'b1, 10, 0);
        apply_stimulus(1'b0, 0, 0);
        apply_stimulus(1'b0, 0, 0);
        apply_stimulus(1'b1, 20, 0);
        check_output("b2b_second_valid", longint'(out_valid), 1);
        check_output("b2b_second_lane0", longint'(dut_lane(0)), 30);
        idle(2);
        check_output("b2b_pulse_count", longint'(pulses - p0), 2);

        // Parameter freeze mid-group
        acc_len = 8'd3; mode = 2'd1;
        apply_stimulus(1'b1, 2, 0);
        mode = 2'd0; acc_len = 8'd5;
        apply_stimulus(1'b1, -5, 0);
        apply_stimulus(1'b1, -5, 0);
        check_output("freeze_valid", longint'(out_valid), 1);
        check_output("freeze_lane0", longint'(dut_lane(0)), 0);
        idle(1);

        // clr aborts a group; the sample presented with clr is dropped
        mode = 2'd1; acc_len = 8'd3;
        p0 = pulses;
        apply_stimulus(1'b1, 4, 0);
        apply_stimulus(1'b1, 4, 0);
        clr = 1'b1;
        apply_stimulus(1'b1, 100, 0);
        clr = 1'b0;
        check_output("clr_no_pulse", longint'(out_valid), 0);
        check_output("clr_busy", longint'(busy), 0);
        idle(2);
        check_output("clr_pulse_count", longint'(pulses - p0), 0);
        apply_stimulus(1'b1, -1, 3);
        apply_stimulus(1'b1, -1, 3);
        apply_stimulus(1'b1, -1, 3);
        check_output("post_clr_valid", longint'(out_valid), 1);
        check_output("post_clr_lane0", longint'(dut_lane(0)), 0);
        check_output("post_clr_lane1", longint'(dut_lane(1)), 9);
        idle(1);

        // Asynchronous reset in the middle of a group
        acc_len = 8'd4; mode = 2'd0;
        apply_stimulus(1'b1, 7, 7);
        apply_stimulus(1'b1, 7, 7);
        check_output("pre_reset_busy", longint'(busy), 1);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_output("async_reset_valid", longint'(out_valid), 0);
        check_output("async_reset_busy", longint'(busy), 0);
        check_output("async_reset_lane1", longint'(dut_lane(1)), 0);
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(1'b1, 1, 0);
        apply_stimulus(1'b1, 2, 0);
        apply_stimulus(1'b1, 3, 0);
        apply_stimulus(1'b1, 4, 0);
        check_output("fresh_group_valid", longint'(out_valid), 1);
        check_output("fresh_group_lane0", longint'(dut_lane(0)), 10);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sfp_acc_act.md
Name: sfp_acc_act

Overview:
Per-column special-function post-processor sitting after the systolic MAC array's output FIFO. It accumulates a programmable number of partial-sum vectors per output group, with signed saturation, and then applies a selectable activation (bypass / ReLU / leaky ReLU). It emits one result vector per group, with a one-cycle valid pulse. Successor to the fixed ReLU accumulator: it adds a valid handshake, group length, activation modes, widened accumulators and saturation flags.

Parameters:
bw, 16, signed width of each input column lane
psum_bw, 20, signed accumulator/output width per lane (psum_bw >= bw)
col, 8, number of column lanes
cnt_bw, 8, width of group-length field and internal sample counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
clr  input  1  synchronous abort of current group
in_valid  input  1  in is a valid sample this cycle
in  input  bw*col  packed signed samples, lane i at [bw*(i+1)-1 : bw*i]
acc_len  input  cnt_bw  samples per group; 0 treated as 1
mode  input  2  0 bypass, 1 ReLU, 2 leaky ReLU, 3 reserved (= bypass)
leak_shift  input  4  arithmetic right-shift amount for negative values in mode 2
out_valid  output  1  one-cycle pulse, out/out_sat valid
out  output  psum_bw*col  packed signed activated results
out_sat  output  col  per-lane flag, saturation occurred during this group
busy  output  1  a group is in progress (count != 0)

Behaviour:
- Reset (reset=0, async): acc, count, out, out_sat, out_valid, busy, and latched mode/leak_shift/len all 0; state IDLE.
- States:
  - IDLE (count==0).
  - ACC (0 < count < len).
- IDLE with in_valid:
  - Latch mode, leak_shift and len = max(acc_len,1).
  - The sample is the group's first; go to ACC. If len==1, complete immediately instead (see Completion).
- Group parameters are frozen until completion; changes to acc_len/mode/leak_shift mid-group are ignored.
- Per accepted sample, per lane:
  - sum = acc + sign_extend(in lane).
  - Clamp to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - Clamping sets the lane's sticky sat bit for the group.
- in_valid=0 cycles are gaps: no count advance, acc held. No backpressure; every in_valid sample is consumed.
- Completion (sample number len accepted at cycle t), at edge t:
  - out <= act(clamped sum).
  - out_sat <= sticky bits including this sample.
  - out_valid=1 during cycle t+1 only.
  - acc, count and sticky bits cleared; state IDLE.
- Latency: last sample to out_valid is exactly 1 cycle.
- Back-to-back: a sample at cycle t+1 starts the next group with no bubble; full throughput is 1 sample/cycle.
- act per lane:
  - mode 0/3: x.
  - mode 1: x<0 ? 0 : x.
  - mode 2: x<0 ? (x >>> leak_shift) : x, rounding toward -inf. leak_shift=0 gives identity.
- out and out_sat hold their last values between pulses; out_valid=0 otherwise.
- clr=1: acc, count and sticky cleared; state IDLE; in same cycle ignored. out/out_sat unchanged. clr has priority over in_valid and completion, so no out_valid pulse results.
- busy = (count != 0), registered state, not combinational on in_valid.
- Reset asserted mid-group: everything is cleared immediately, with no pulse. After release, the first in_valid starts a fresh group.

Test Plan:
- Reset during group: acc_len=4, send 2 samples, pull reset low mid-cycle -> out=0, out_valid=0, busy=0 immediately. After release, a fresh 4-sample group yields the correct sum.
- ReLU group: acc_len=3, mode=1; lane0 5,-2,4; lane1 -5,1,1 -> one cycle after the 3rd sample, out_valid=1, lane0=7, lane1=0, out_sat=0.
- Leaky: acc_len=1, mode=2, leak_shift=2; lane0 -9, lane1 12 -> lane0=-3, lane1=12.
- Saturation: mode=0, acc_len=20; lane0 32767 every sample -> lane0=524287, out_sat[0]=1. Lane1 -32768 x20 -> -524288, out_sat[1]=1. Other lanes out_sat=0.
- Back-to-back and gaps: acc_len=2, in_valid pattern 1,1,1,0,0,1 with lane0 1,2,10,-,-,20:
  - pulse 1 cycle after the 2nd sample, lane0=3.
  - pulse 1 cycle after the 6th cycle, lane0=30.
  - exactly two pulses.
- clr and param freeze: acc_len=3, mode=1; after sample 1 change mode to 0 and acc_len to 5 -> group still ends after 3 samples with ReLU applied. Separately, clr after sample 2 -> no pulse. The next 3 samples (-1,-1,-1) give lane0=0 (ReLU latched at new group start if mode=1).
